// File: rtl/const_fetch_seq_pkg.sv
// rtl/const_fetch_seq_pkg.sv - shared widths, FSM encoding and request check for const_fetch_seq
package const_fetch_seq_pkg;
  localparam int CONST_ADDR_W = 13;
  localparam int CONST_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A fetch may cover at most one whole sector, so idx never wraps into the next one.
  function automatic logic count_legal(input logic [31:0] cnt, input int idx_w);
    return (cnt != 32'd0) && (cnt <= (32'd1 << idx_w));
  endfunction
endpackage

// File: rtl/const_fetch_fifo.sv
// rtl/const_fetch_fifo.sv - first-word-fall-through skid FIFO holding {last, data} entries
module const_fetch_fifo #(
  parameter int W = 9,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic                 push_i,
  input  logic [W-1:0]         push_data_i,
  input  logic                 pop_i,
  output logic [W-1:0]         head_o,
  output logic [$clog2(D):0]   count_o,
  output logic                 empty_o,
  output logic                 full_o
);
  localparam int AW = $clog2(D);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!init_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/const_fetch_seq.sv
// rtl/const_fetch_seq.sv - constant bank read initiator: issues {sector,idx} reads, streams bytes out
module const_fetch_seq
  import const_fetch_seq_pkg::*;
#(
  parameter int SEC_W  = 6,
  parameter int IDX_W  = 7,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic                    clk,
  input  logic                    init_n,
  input  logic                    tmode,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SEC_W-1:0]        req_sector,
  input  logic [IDX_W:0]          req_count,
  output logic [CONST_ADDR_W-1:0] const_full_addr,
  input  logic [CONST_DATA_W-1:0] const_addr,
  output logic [CONST_DATA_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    done,
  output logic                    err
);
  localparam int CW = $clog2(FIFO_D) + 1;
  localparam int SW = CW + 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [IDX_W:0]   LEFT_ONE = 1;

  state_e                  state_q;
  logic [SEC_W-1:0]        sector_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W:0]          left_q;
  logic [CONST_ADDR_W-1:0] addr_q;
  logic                    done_q, err_q;
  logic [RD_LAT-1:0]       tag_v_q, tag_l_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [8:0]    fifo_head;
  logic [SW-1:0] inflight;
  logic          credit_ok, issue, push, pop;

  // Reads already launched hold a FIFO slot until they land, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(tag_v_q[i]);
  end

  assign credit_ok = (SW'(fifo_count) + inflight) < SW'(FIFO_D);
  assign issue     = (state_q == ST_FETCH) && !tmode && credit_ok;
  assign push      = tag_v_q[RD_LAT-1] && !fifo_full;
  assign pop       = out_valid && out_ready;

  assign req_ready       = init_n && (state_q == ST_IDLE);
  assign const_full_addr = addr_q;
  assign done            = done_q;
  assign err             = err_q;
  assign out_valid       = !fifo_empty;
  assign out_last        = fifo_head[8];
  assign out_data        = fifo_head[7:0];

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q  <= ST_IDLE;
      sector_q <= '0;
      idx_q    <= '0;
      left_q   <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tag_v_q  <= '0;
      tag_l_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tag_v_q[0] <= issue;
      tag_l_q[0] <= issue && (left_q == LEFT_ONE);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (count_legal(32'(req_count), IDX_W)) begin
              sector_q <= req_sector;
              idx_q    <= '0;
              left_q   <= req_count;
              state_q  <= ST_FETCH;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            addr_q <= {sector_q, idx_q};
            idx_q  <= idx_q + IDX_ONE;
            left_q <= left_q - LEFT_ONE;
            if (left_q == LEFT_ONE) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  const_fetch_fifo #(.W(9), .D(FIFO_D)) u_fifo (
    .clk         (clk),
    .init_n      (init_n),
    .push_i      (push),
    .push_data_i ({tag_l_q[RD_LAT-1], const_addr}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );
endmodule

// File: tb/tb_const_fetch_seq.sv
// tb/tb_const_fetch_seq.sv - self-checking bench for const_fetch_seq
module tb_const_fetch_seq;
  localparam int SEC_W  = 6;
  localparam int IDX_W  = 7;
  localparam int RD_LAT = 1;
  localparam int FIFO_D = 4;
  localparam int SEC_SZ = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             init_n = 1'b0;
  logic             tmode = 1'b0;
  logic             req_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [SEC_W-1:0] req_sector = '0;
  logic [IDX_W:0]   req_count = '0;
  logic             req_ready, out_valid, out_last, done, err;
  logic [12:0]      const_full_addr;
  logic [7:0]       const_addr, out_data;

  logic [7:0] bank_mem [8192];
  int checks = 0;
  int failures = 0;

  logic [8:0]  obs_q[$];
  int          xcyc_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          err_cnt = 0;
  int          tviol = 0;
  logic        prev_t = 1'b0;
  logic [12:0] prev_a = '0;

  always #5 clk = ~clk;

  assign const_addr = bank_mem[const_full_addr];

  const_fetch_seq #(.SEC_W(SEC_W), .IDX_W(IDX_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk             (clk),
    .init_n          (init_n),
    .tmode           (tmode),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_sector      (req_sector),
    .req_count       (req_count),
    .const_full_addr (const_full_addr),
    .const_addr      (const_addr),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .done            (done),
    .err             (err)
  );

  // Inputs change only just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (prev_t && (const_full_addr !== prev_a)) tviol++;
    prev_t = tmode;
    prev_a = const_full_addr;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_last, out_data});
      xcyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (err) err_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: free-running, 1: 20-cycle stall after 2nd byte, 2: tmode toggles every 3 cycles,
  // 3: random out_ready and tmode
  task automatic run_fetch(input int sec, input int cnt, input int mode, input string tag);
    logic [8:0]  exp_q[$];
    logic [12:0] a;
    int base, dbase, ebase, k, bp_phase, bp_left;
    for (int i = 0; i < cnt; i++) begin
      a = 13'(sec * SEC_SZ + i);
      exp_q.push_back({(i == cnt - 1), bank_mem[a]});
    end
    base  = obs_q.size();
    dbase = done_cnt;
    ebase = err_cnt;
    out_ready  = 1'b1;
    tmode      = 1'b0;
    req_sector = SEC_W'(sec);
    req_count  = (IDX_W+1)'(cnt);
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    k = 0;
    bp_phase = 0;
    bp_left = 0;
    while (done_cnt == dbase && k < 3000) begin
      case (mode)
        1: begin
          if (bp_phase == 0 && obs_q.size() - base >= 2) begin
            bp_phase = 1;
            bp_left = 20;
          end
          if (bp_phase == 1 && bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
          end else begin
            if (bp_phase == 1) begin
              chk({tag, " stall_bytes"}, 32'(obs_q.size() - base), 32'd2);
              chk({tag, " stall_valid"}, 32'(out_valid), 32'd1);
              chk({tag, " stall_addr"}, 32'(const_full_addr), 32'(sec * SEC_SZ + 1 + FIFO_D));
              bp_phase = 2;
            end
            out_ready = 1'b1;
          end
        end
        2: tmode = ((k / 3) % 2) == 1;
        3: begin
          out_ready = ($urandom_range(0, 3) != 0);
          tmode     = ($urandom_range(0, 3) == 0);
        end
        default: out_ready = 1'b1;
      endcase
      if (!req_ready && $urandom_range(0, 3) == 0) begin
        req_valid  = 1'b1;
        req_sector = SEC_W'($urandom);
        req_count  = (IDX_W+1)'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      k++;
    end
    req_valid = 1'b0;
    tmode = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk({tag, " done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    chk({tag, " err_pulses"}, 32'(err_cnt - ebase), 32'd0);
    chk({tag, " nbytes"}, 32'(obs_q.size() - base), 32'(cnt));
    for (int i = 0; i < cnt && base + i < obs_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    if (obs_q.size() > base)
      chk({tag, " done_lat"}, 32'(done_cyc), 32'(xcyc_q[xcyc_q.size() - 1] + 1));
    if (mode == 0 && obs_q.size() - base == cnt)
      chk({tag, " zero_bubble"}, 32'(xcyc_q[base + cnt - 1] - xcyc_q[base]), 32'(cnt - 1));
    chk({tag, " tmode_issue"}, 32'(tviol), 32'd0);
    chk({tag, " idle_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_illegal(input int cnt, input string tag);
    logic [12:0] a0;
    int base;
    a0 = const_full_addr;
    base = obs_q.size();
    req_sector = SEC_W'($urandom);
    req_count  = (IDX_W+1)'(cnt);
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " err"}, 32'(err), 32'd1);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    tick();
    tick();
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    chk({tag, " no_issue"}, 32'(const_full_addr), 32'(a0));
    chk({tag, " no_bytes"}, 32'(obs_q.size() - base), 32'd0);
  endtask

  initial begin
    int dbase, sec, cnt;
    for (int i = 0; i < 8192; i++) bank_mem[i] = 8'(i);

    tick(); tick(); tick();
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst addr", 32'(const_full_addr), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    init_n = 1'b1;
    tick();
    chk("rst release ready", 32'(req_ready), 32'd1);

    run_fetch(5, 4, 0, "basic");
    chk("basic last addr", 32'(const_full_addr), 32'h283);
    chk("basic first byte", 32'(obs_q[obs_q.size() - 4]), 32'h080);
    chk("basic last byte", 32'(obs_q[obs_q.size() - 1]), 32'h183);

    for (int i = 0; i < 8192; i++) bank_mem[i] = 8'($urandom);

    run_fetch(63, 128, 0, "full_sector");
    chk("full_sector last addr", 32'(const_full_addr), 32'h1FFF);

    run_fetch(9, 10, 1, "backpressure");
    run_fetch(20, 16, 2, "tmode");

    run_illegal(0, "illegal0");
    run_illegal(129, "illegal129");

    // Reset in the middle of a fetch must drop everything without a done pulse.
    dbase = done_cnt;
    out_ready = 1'b1;
    req_sector = 6'd3;
    req_count = 8'd16;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    init_n = 1'b0;
    tick(); tick(); tick();
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst addr", 32'(const_full_addr), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd0);
    init_n = 1'b1;
    tick();
    chk("midrst release ready", 32'(req_ready), 32'd1);
    tick(); tick(); tick();
    chk("midrst no done", 32'(done_cnt - dbase), 32'd0);
    chk("midrst fifo empty", 32'(out_valid), 32'd0);

    for (int n = 0; n < 6; n++) begin
      sec = $urandom_range(0, (1 << SEC_W) - 1);
      cnt = $urandom_range(1, SEC_SZ);
      run_fetch(sec, cnt, 3, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
